// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and store lane helper for the memory stage
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, DONE} lsu_state_t;

   function automatic logic isByteOp(input logic [2:0] funct3);
      return funct3 == F3_LB || funct3 == F3_LBU;
   endfunction

   function automatic logic isHalfOp(input logic [2:0] funct3);
      return funct3 == F3_LH || funct3 == F3_LHU;
   endfunction

   function automatic logic [3:0] st_be(input logic [2:0] funct3, input logic [1:0] addr);
      return isByteOp(funct3) ? 4'b0001 << addr : isHalfOp(funct3) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// load_ext: picks the addressed byte/half of a load word and sign- or zero-extends it
module load_ext
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] ext
);

   logic [7:0]  bSel;
   logic [15:0] hSel;
   logic        sgn;

   // funct3[2] set means unsigned; sizes outside byte/half pass the word through
   always_comb begin
      bSel = word[{addr, 3'b000} +: 8];
      hSel = addr[1] ? word[31:16] : word[15:0];
      sgn  = ~funct3[2];
      ext  = isByteOp(funct3) ? {{24{bSel[7] & sgn}}, bSel} :
             isHalfOp(funct3) ? {{16{hSel[15] & sgn}}, hSel} : word;
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: drives the data-memory bus for loads/stores and stalls the pipeline until done
module mem_stage
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        validm,
   input  logic        memRdm,
   input  logic        memWrtm,
   input  logic [2:0]  funct3m,
   input  logic [31:0] aluRsltm,
   input  logic [31:0] wrtDatam,
   input  logic        regWrtm,
   output logic        regWrtq,
   output logic [31:0] readDm,
   output logic        stallm,
   output logic        misAlgn,
   output logic        dmReq,
   output logic        dmWe,
   output logic [29:0] dmAddr,
   output logic [3:0]  dmBe,
   output logic [31:0] dmWdata,
   input  logic        dmGnt,
   input  logic        dmRvalid,
   input  logic [31:0] dmRdata
);

   lsu_state_t  state, nextState;
   logic [31:0] ldQ, extData;
   logic        isByte, isHalf, memOp, acc;

   assign isByte  = isByteOp(funct3m);
   assign isHalf  = isHalfOp(funct3m);
   assign memOp   = validm & (memRdm | memWrtm);
   assign misAlgn = memOp & (isHalf & aluRsltm[0] | ~isByte & ~isHalf & |aluRsltm[1:0]);
   assign acc     = memOp & ~misAlgn;
   assign regWrtq = regWrtm & ~misAlgn;

   // request fields come straight from the held EX/MEM register, so they stay stable while waiting
   assign dmWe    = memWrtm;
   assign dmAddr  = aluRsltm[31:2];
   assign dmBe    = memWrtm ? st_be(funct3m, aluRsltm[1:0]) : 4'b1111;
   assign dmWdata = isByte ? {4{wrtDatam[7:0]}} : isHalf ? {2{wrtDatam[15:0]}} : wrtDatam;

   load_ext uExt (
      .word   (dmRdata),
      .addr   (aluRsltm[1:0]),
      .funct3 (funct3m),
      .ext    (extData)
   );

   // state register; load data is captured only when the response arrives in WAIT_RSP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ldQ   <= '0;
      end else begin
         state <= nextState;
         if (state == WAIT_RSP && dmRvalid) ldQ <= extData;
      end
   end

   // next-state: stores finish at grant, loads wait for the response
   always_comb begin
      nextState = state;
      case (state)
         IDLE:     if (acc) nextState = dmGnt ? (memWrtm ? DONE : WAIT_RSP) : WAIT_GNT;
         WAIT_GNT: if (dmGnt) nextState = memWrtm ? DONE : WAIT_RSP;
         WAIT_RSP: if (dmRvalid) nextState = DONE;
         default:  nextState = IDLE;
      endcase
   end

   // outputs: request is suppressed during reset, DONE releases the pipeline
   always_comb begin
      dmReq  = rst_n & (state == IDLE ? acc : state == WAIT_GNT);
      stallm = state == IDLE ? acc : (state == WAIT_GNT || state == WAIT_RSP);
      readDm = state == DONE ? ldQ : '0;
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage bus handshake, lanes, extension and reset
module tb_mem_stage;
   import lsu_pkg::*;

   logic        clk = 0, rst_n = 0;
   logic        validm = 0, memRdm = 0, memWrtm = 0, regWrtm = 0;
   logic [2:0]  funct3m = 0;
   logic [31:0] aluRsltm = 0, wrtDatam = 0;
   logic        regWrtq, stallm, misAlgn, dmReq, dmWe;
   logic [31:0] readDm, dmWdata;
   logic [29:0] dmAddr;
   logic [3:0]  dmBe;
   logic        dmGnt = 0, dmRvalid = 0;
   logic [31:0] dmRdata = 0;
   int          errCnt = 0, chkCnt = 0, stallCnt;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst_n(rst_n), .validm(validm), .memRdm(memRdm), .memWrtm(memWrtm),
      .funct3m(funct3m), .aluRsltm(aluRsltm), .wrtDatam(wrtDatam), .regWrtm(regWrtm),
      .regWrtq(regWrtq), .readDm(readDm), .stallm(stallm), .misAlgn(misAlgn),
      .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmBe(dmBe), .dmWdata(dmWdata),
      .dmGnt(dmGnt), .dmRvalid(dmRvalid), .dmRdata(dmRdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic setOp(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      validm = v; memRdm = rd; memWrtm = wr; funct3m = f3; aluRsltm = a; wrtDatam = wd; regWrtm = rd;
   endtask

   // load with grant in cycle 0 and response in cycle 1, result visible in DONE
   task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
      setOp(1, 1, 0, f3, a, 0); dmGnt = 1; #1;
      check({tag, " req0"}, dmReq, 1);
      check({tag, " stall0"}, stallm, 1);
      check({tag, " be"}, dmBe, 4'hF);
      tick; dmGnt = 0; dmRvalid = 1; dmRdata = rd; #1;
      check({tag, " stall1"}, stallm, 1);
      check({tag, " req1"}, dmReq, 0);
      tick; dmRvalid = 0; dmRdata = 0; #1;
      check({tag, " stall2"}, stallm, 0);
      check({tag, " data"}, readDm, exp);
      check({tag, " regwrt"}, regWrtq, 1);
      tick; setOp(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // reset with a pending load present: request must stay low
      setOp(1, 1, 0, F3_LW, 32'h0, 0); #3;
      check("rst req", dmReq, 0);
      check("rst readDm", readDm, 0);
      check("rst misAlgn", misAlgn, 0);
      #10; setOp(0, 0, 0, 0, 0, 0); rst_n = 1;
      tick;

      // non-memory instruction passes through without stalling
      validm = 1; regWrtm = 1; #1;
      check("alu stall", stallm, 0);
      check("alu req", dmReq, 0);
      check("alu regwrt", regWrtq, 1);
      tick; setOp(0, 0, 0, 0, 0, 0);

      doLoad("lb", F3_LB, 32'h103, 32'h8000_0000, 32'hFFFF_FF80);
      doLoad("lhu", F3_LHU, 32'h002, 32'hF00D_0000, 32'h0000_F00D);
      doLoad("lh", F3_LH, 32'h000, 32'h1234_8001, 32'hFFFF_8001);
      doLoad("lbu", F3_LBU, 32'h102, 32'h00C3_0000, 32'h0000_00C3);

      // sh upper half with same-cycle grant
      setOp(1, 0, 1, 3'b001, 32'h202, 32'h1234_ABCD); dmGnt = 1; #1;
      check("sh be", dmBe, 4'b1100);
      check("sh wdata", dmWdata, 32'hABCD_ABCD);
      check("sh we", dmWe, 1);
      check("sh req", dmReq, 1);
      check("sh stall0", stallm, 1);
      check("sh addr", dmAddr, 30'h80);
      tick; dmGnt = 0; #1;
      check("sh stall1", stallm, 0);
      check("sh req1", dmReq, 0);
      tick; setOp(0, 0, 0, 0, 0, 0);

      // sb lane 1
      setOp(1, 0, 1, 3'b000, 32'h001, 32'h0000_00A5); dmGnt = 1; #1;
      check("sb be", dmBe, 4'b0010);
      check("sb wdata", dmWdata, 32'hA5A5_A5A5);
      check("sb misAlgn", misAlgn, 0);
      tick; dmGnt = 0; #1;
      check("sb stall1", stallm, 0);
      tick; setOp(0, 0, 0, 0, 0, 0);

      // grant withheld for 3 cycles
      setOp(1, 1, 0, F3_LW, 32'h300, 0); dmGnt = 0; stallCnt = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("gd req", dmReq, 1);
         check("gd addr", dmAddr, 30'hC0);
         stallCnt += int'(stallm);
         tick;
      end
      dmGnt = 1; #1;
      check("gd req gnt", dmReq, 1);
      check("gd addr gnt", dmAddr, 30'hC0);
      stallCnt += int'(stallm);
      tick; dmGnt = 0; dmRvalid = 1; dmRdata = 32'hDEAD_BEEF; #1;
      check("gd req rsp", dmReq, 0);
      stallCnt += int'(stallm);
      tick; dmRvalid = 0; #1;
      check("gd data", readDm, 32'hDEAD_BEEF);
      stallCnt += int'(stallm);
      check("gd stall cycles", stallCnt, 5);
      tick; setOp(0, 0, 0, 0, 0, 0);

      // misaligned word load
      setOp(1, 1, 0, F3_LW, 32'h101, 0); dmGnt = 1; #1;
      check("mis flag", misAlgn, 1);
      check("mis req", dmReq, 0);
      check("mis stall", stallm, 0);
      check("mis regwrt", regWrtq, 0);
      tick; dmGnt = 0; #1;
      check("mis stays idle", stallm, 0);
      tick; setOp(0, 0, 0, 0, 0, 0);

      // misaligned half, aligned half at offset 2 is fine
      setOp(1, 0, 1, F3_LH, 32'h003, 0); #1;
      check("mis half", misAlgn, 1);
      aluRsltm = 32'h002; #1;
      check("half ok", misAlgn, 0);
      setOp(0, 0, 0, 0, 0, 0);

      // reset while waiting for a response; the late response must be dropped
      setOp(1, 1, 0, F3_LW, 32'h010, 0); dmGnt = 1; #1;
      check("rr req", dmReq, 1);
      tick; dmGnt = 0; #1;
      check("rr waiting", stallm, 1);
      rst_n = 0; #1;
      check("rr req low", dmReq, 0);
      check("rr readDm", readDm, 0);
      rst_n = 1; setOp(0, 0, 0, 0, 0, 0); dmRvalid = 1; dmRdata = 32'h5555_5555; #1;
      check("rr stall", stallm, 0);
      tick; dmRvalid = 0; #1;
      check("rr no done", readDm, 0);
      check("rr idle", stallm, 0);
      // store reaches DONE: load register must have been cleared by reset
      setOp(1, 0, 1, F3_LW, 32'h020, 32'h1111_2222); dmGnt = 1; #1;
      check("rr sw req", dmReq, 1);
      tick; dmGnt = 0; #1;
      check("rr ldQ cleared", readDm, 0);
      tick; setOp(0, 0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
